scrambler_64bit: RTL and testbench
==================================

SCRAMBLER_64BIT -- requirements
Module: scrambler_64bit

Interface
REQ-001 Parameter SEED, default 58'h3FF_FFFF_FFFF_FFFF: LFSR state loaded at reset.
REQ-002 CLK  in  1  sole clock; all flops rising-edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 in_data  in  64  unscrambled 64b/66b payload; bit 0 is transmitted first.
REQ-005 in_hdr  in  2  sync header, passed through unscrambled.
REQ-006 in_valid  in  1 / in_ready  out  1  input handshake; beat accepted when both are high.
REQ-007 out_data  out  64 / out_hdr  out  2  scrambled payload and its header.
REQ-008 out_valid  out  1 / out_ready  in  1  output handshake; beat consumed when both are high.
REQ-009 bypass  in  1  sampled on accept; 1 = payload passes unscrambled.
REQ-010 seed_load  in  1 / seed_value  in  58  synchronous state overwrite.
REQ-011 hdr_err_cnt  out  16  saturating count of accepted beats with an invalid header.

Function
REQ-012 Scrambling: self-synchronous, g(x)=x^58+x^39+1, out[i] = in[i] ^ h(i-39) ^ h(i-58), for i = 0..63.
REQ-013 The history term h(k) resolves as follows.
- For k>=0: h(k) = out[k] of the current word.
- For k<0: h(k) = S[58+k], where S is the 58-bit state.
REQ-014 On each accept, S <= new out[63:6], i.e. S[j] = out[j+6].
REQ-015 S advances only on accepted beats; idle and stall cycles leave S unchanged.
REQ-016 Bypass beat: out_data = in_data, and S <= in_data[63:6], so scrambling resumes seamlessly when bypass is cleared.
REQ-017 out_hdr equals in_hdr of the same beat; the header never affects S.
REQ-018 Valid headers are 2'b01 (data) and 2'b10 (control).
- A header of 2'b00 or 2'b11 increments hdr_err_cnt, saturating at 16'hFFFF.
- The payload of such a beat is still scrambled normally.
REQ-019 Datapath structure: one-cycle registered output stage plus a one-entry skid buffer.
- Latency is 1 cycle from accept to out_valid.
- Full throughput is sustained when out_ready is continuously high.
REQ-020 in_ready is driven directly from a flop and equals "skid buffer empty".
REQ-021 If out_ready is low while the output stage is full, the next accepted beat goes to the skid buffer and in_ready deasserts the following cycle.
REQ-022 Beats are never dropped, duplicated or reordered.
REQ-023 out_data and out_hdr stay stable while out_valid=1 and out_ready=0.
REQ-024 seed_load with no accept in the same cycle: S <= seed_value.
REQ-025 seed_load coincident with an accept: the accepted beat is scrambled with the old S, then S <= seed_value (seed wins).
REQ-026 seed_load does not flush beats already in the output stage or skid buffer.

Reset
REQ-027 While rst_n=0, and immediately on its assertion:
- S = SEED
- out_valid = 0, skid buffer empty, in_ready = 0
- out_data = 0, out_hdr = 0, hdr_err_cnt = 0
REQ-028 in_ready rises on the first CLK edge after rst_n deasserts.
REQ-029 Reset asserted mid-stream discards all buffered beats and has no synchronous-reset dependency.

Structure
REQ-030 Shared package scrambler_pkg holds the constants:
- LFSR_WIDTH=58, DATA_WIDTH=64, TAP_A=39, TAP_B=58
- HDR_DATA=2'b01, HDR_CTRL=2'b10
REQ-031 The combinational 64-bit unrolled step (in_data, S) -> (out_data, next S) lives in one sub-module, scrambler_64bit_step.
REQ-032 Handshake, skid buffer, state register and counter live in scrambler_64bit.

Verification
REQ-033 Reset with SEED all-ones, then accept in_data=64'h0, hdr=2'b01 -> out_data=64'h03FF_FF80_0000_0000, out_hdr=2'b01, one cycle after accept.
REQ-034 Stream 1000 random beats through a bench descrambler model -> recovered data matches input from beat 2 onward; also check with a random initial S.
REQ-035 in_valid held high, out_ready low for 5 cycles -> exactly 2 beats accepted, in_ready=0 until out_ready rises; all beats then emerge in order with no gaps.
REQ-036 Set bypass=1, send 64'h0123_4567_89AB_CDEF -> out_data is identical; then bypass=0, send 0 -> output matches the model using S = 64'h0123_4567_89AB_CDEF[63:6].
REQ-037 Header error counting:
- Three beats with hdr=2'b00 -> hdr_err_cnt=3.
- Preload the count to 16'hFFFF, send hdr=2'b11 -> count stays 16'hFFFF.
REQ-038 Drop rst_n while out_valid=1 and the skid buffer is full -> out_valid falls without a clock edge; after release, zero input again gives 64'h03FF_FF80_0000_0000.

Source files
------------

// File: rtl/scrambler_pkg.sv
// Shared constants and beat type for the 64b/66b self-synchronous scrambler.
package scrambler_pkg;

  localparam int LFSR_WIDTH = 58;
  localparam int DATA_WIDTH = 64;
  localparam int TAP_A      = 39;
  localparam int TAP_B      = 58;

  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;

  typedef struct packed {
    logic [1:0]            hdr;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  function automatic logic hdr_is_valid(input logic [1:0] hdr);
    return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
  endfunction

endpackage

// File: rtl/scrambler_64bit_if.sv
// Stream bus for the scrambler: input beat handshake and output beat handshake.
interface scrambler_64bit_if;
  import scrambler_pkg::*;

  logic [DATA_WIDTH-1:0] in_data;
  logic [1:0]            in_hdr;
  logic                  in_valid;
  logic                  in_ready;
  logic                  bypass;
  logic [DATA_WIDTH-1:0] out_data;
  logic [1:0]            out_hdr;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_hdr, in_valid, bypass, out_ready,
    input  in_ready, out_data, out_hdr, out_valid
  );

  modport slave (
    input  in_data, in_hdr, in_valid, bypass, out_ready,
    output in_ready, out_data, out_hdr, out_valid
  );

endinterface

// File: rtl/scrambler_64bit_step.sv
// Combinational 64-bit unrolled step of the x^58+x^39+1 self-synchronous scrambler.
module scrambler_64bit_step
  import scrambler_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state,
  input  logic                  bypass,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LFSR_WIDTH-1:0] state_next
);

  // h holds the state as the 58 oldest bits, followed by each new output bit,
  // so taps reaching back past bit 0 of the word land in the state.
  function automatic logic [DATA_WIDTH-1:0] scramble(
    input logic [DATA_WIDTH-1:0] d,
    input logic [LFSR_WIDTH-1:0] s
  );
    logic [LFSR_WIDTH+DATA_WIDTH-1:0] h;
    h = '0;
    h[LFSR_WIDTH-1:0] = s;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      h[LFSR_WIDTH+i] = d[i] ^ h[LFSR_WIDTH-TAP_A+i] ^ h[LFSR_WIDTH-TAP_B+i];
    end
    return h[LFSR_WIDTH+DATA_WIDTH-1:LFSR_WIDTH];
  endfunction

  logic [DATA_WIDTH-1:0] scrambled;

  always_comb begin
    scrambled  = scramble(data_in, state);
    data_out   = bypass ? data_in : scrambled;
    // Bypass still feeds the raw payload into the history, so resuming is seamless.
    state_next = data_out[DATA_WIDTH-1 -: LFSR_WIDTH];
  end

endmodule

// File: rtl/scrambler_64bit.sv
// 64b/66b payload scrambler with registered output stage, skid buffer and header error counter.
module scrambler_64bit
  import scrambler_pkg::*;
#(
  parameter logic [LFSR_WIDTH-1:0] SEED = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  scrambler_64bit_if.slave      bus,
  input  logic                  seed_load,
  input  logic [LFSR_WIDTH-1:0] seed_value,
  output logic [15:0]           hdr_err_cnt
);

  logic [LFSR_WIDTH-1:0] state_q;
  logic [LFSR_WIDTH-1:0] state_next;
  logic [DATA_WIDTH-1:0] step_data;
  beat_t                 out_q;
  beat_t                 skid_q;
  beat_t                 new_beat;
  logic                  out_valid_q;
  logic                  skid_valid_q;
  logic                  skid_valid_d;
  logic                  in_ready_q;
  logic                  accept;
  logic                  load_out;
  logic [15:0]           err_q;

  scrambler_64bit_step u_step (
    .data_in    (bus.in_data),
    .state      (state_q),
    .bypass     (bus.bypass),
    .data_out   (step_data),
    .state_next (state_next)
  );

  assign accept   = bus.in_valid & in_ready_q;
  assign load_out = ~out_valid_q | bus.out_ready;
  assign new_beat = {bus.in_hdr, step_data};

  // in_ready is low whenever the skid holds a beat, so accept never coincides with a full skid.
  always_comb begin
    skid_valid_d = skid_valid_q;
    if (load_out) begin
      skid_valid_d = 1'b0;
    end else if (accept) begin
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else if (seed_load) begin
      state_q <= seed_value;
    end else if (accept) begin
      state_q <= state_next;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= ~skid_valid_d;
      if (load_out) begin
        if (skid_valid_q) begin
          out_valid_q <= 1'b1;
          out_q       <= skid_q;
        end else begin
          out_valid_q <= accept;
          if (accept) begin
            out_q <= new_beat;
          end
        end
      end else if (accept) begin
        skid_q <= new_beat;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (accept && !hdr_is_valid(bus.in_hdr) && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q.data;
  assign bus.out_hdr   = out_q.hdr;
  assign hdr_err_cnt   = err_q;

endmodule

// File: tb/tb_scrambler_64bit.sv
// Self-checking bench for scrambler_64bit: vector table, directed corners and a random stream.
module tb_scrambler_64bit;
  import scrambler_pkg::*;

  localparam logic [57:0] SEED_C = 58'h3FF_FFFF_FFFF_FFFF;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        seed_load;
  logic [57:0] seed_value;
  logic [15:0] hdr_err_cnt;

  always #5 CLK = ~CLK;

  scrambler_64bit_if bus ();

  scrambler_64bit #(.SEED(SEED_C)) dut (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .seed_load   (seed_load),
    .seed_value  (seed_value),
    .hdr_err_cnt (hdr_err_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Serial-bitstream reference: the line is a bit sequence, each new bit xors
  // the bits transmitted 39 and 58 positions earlier.
  function automatic logic [63:0] ref_scramble(input logic [63:0] d, input logic byp,
                                               input logic [57:0] s, output logic [57:0] ns);
    bit q[$];
    bit b;
    logic [63:0] o;
    for (int j = 0; j < 58; j++) q.push_back(s[j]);
    for (int i = 0; i < 64; i++) begin
      b = byp ? d[i] : (d[i] ^ q[q.size()-TAP_A] ^ q[q.size()-TAP_B]);
      o[i] = b;
      q.push_back(b);
      void'(q.pop_front());
    end
    for (int j = 0; j < 58; j++) ns[j] = q[j];
    return o;
  endfunction

  function automatic logic [63:0] ref_descramble(input logic [63:0] o, input logic [57:0] s,
                                                 output logic [57:0] ns);
    bit q[$];
    logic [63:0] d;
    for (int j = 0; j < 58; j++) q.push_back(s[j]);
    for (int i = 0; i < 64; i++) begin
      d[i] = o[i] ^ q[q.size()-TAP_A] ^ q[q.size()-TAP_B];
      q.push_back(o[i]);
      void'(q.pop_front());
    end
    for (int j = 0; j < 58; j++) ns[j] = q[j];
    return d;
  endfunction

  logic [65:0] exp_q[$];
  logic [63:0] src_q[$];
  logic [57:0] model_s;
  logic [57:0] rx_s;
  int          model_cnt;
  bit          mon_en;
  bit          desc_en;
  int          desc_idx;
  logic [65:0] mon_e;
  logic [63:0] mon_d;
  logic [63:0] mon_src;
  logic [57:0] mon_ns;

  // Scoreboard: sampled 1 unit after the driving edge, values hold until the next posedge.
  always @(negedge CLK) begin
    #1;
    if (mon_en && rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: actual=%h required=none", bus.out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_data", bus.out_data, mon_e[63:0]);
          chk("sb_hdr", {62'd0, bus.out_hdr}, {62'd0, mon_e[65:64]});
        end
        if (desc_en && src_q.size() > 0) begin
          mon_d   = ref_descramble(bus.out_data, rx_s, mon_ns);
          rx_s    = mon_ns;
          mon_src = src_q.pop_front();
          if (desc_idx >= 1) chk("descramble", mon_d, mon_src);
          desc_idx++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        mon_d   = ref_scramble(bus.in_data, bus.bypass, model_s, mon_ns);
        model_s = mon_ns;
        exp_q.push_back({bus.in_hdr, mon_d});
        if (desc_en) src_q.push_back(bus.in_data);
        if (!(bus.in_hdr == HDR_DATA || bus.in_hdr == HDR_CTRL) && model_cnt != 65535)
          model_cnt++;
      end
      if (seed_load) model_s = seed_value;
    end
  end

  task automatic do_reset(input string tag);
    @(negedge CLK);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk({tag, "_out_valid"}, {63'd0, bus.out_valid}, 64'd0);
    chk({tag, "_in_ready"}, {63'd0, bus.in_ready}, 64'd0);
    chk({tag, "_out_data"}, bus.out_data, 64'd0);
    chk({tag, "_out_hdr"}, {62'd0, bus.out_hdr}, 64'd0);
    chk({tag, "_err_cnt"}, {48'd0, hdr_err_cnt}, 64'd0);
    exp_q.delete();
    src_q.delete();
    model_s   = SEED_C;
    model_cnt = 0;
    repeat (2) @(negedge CLK);
    chk({tag, "_in_ready_held"}, {63'd0, bus.in_ready}, 64'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge CLK);
    chk({tag, "_in_ready_rise"}, {63'd0, bus.in_ready}, 64'd1);
  endtask

  task automatic drain();
    int cyc = 0;
    @(negedge CLK);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(negedge CLK);
      cyc++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending=%0d required=0", exp_q.size());
    end
  endtask

  task automatic random_pass(input int n);
    int sent = 0;
    int cyc  = 0;
    desc_en  = 1'b1;
    desc_idx = 0;
    rx_s     = '0;
    while (sent < n && cyc < n * 20) begin
      @(negedge CLK);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = {$urandom, $urandom};
      bus.in_hdr    = ($urandom_range(0, 1) != 0) ? HDR_DATA : HDR_CTRL;
      bus.bypass    = 1'b0;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (bus.in_valid && bus.in_ready) sent++;
      cyc++;
    end
    if (sent < n) begin
      checks++;
      errors++;
      $display("FAIL random_timeout: sent=%0d required=%0d", sent, n);
    end
    drain();
    desc_en = 1'b0;
  endtask

  typedef struct {
    logic [63:0] data;
    logic [1:0]  hdr;
    logic        byp;
    logic [63:0] exp;
  } vec_t;

  vec_t        vt[4];
  logic [63:0] tmp64;
  logic [57:0] s_a;
  logic [57:0] s_b;
  logic [57:0] s_c;
  logic [63:0] d1;
  logic [63:0] d2;
  logic [63:0] exp2;
  int          acc;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_hdr    = HDR_DATA;
    bus.bypass    = 1'b0;
    bus.out_ready = 1'b1;
    seed_load     = 1'b0;
    seed_value    = '0;
    rst_n         = 1'b1;
    mon_en        = 1'b0;
    desc_en       = 1'b0;
    model_s       = SEED_C;
    model_cnt     = 0;

    tmp64 = 64'h0123_4567_89AB_CDEF;
    s_a   = tmp64[63:6];
    vt[0] = '{64'h0, HDR_DATA, 1'b0, 64'h03FF_FF80_0000_0000};
    vt[1] = '{tmp64, HDR_CTRL, 1'b1, tmp64};
    vt[2] = '{64'h0, HDR_DATA, 1'b0, 64'h0};
    vt[2].exp = ref_scramble(64'h0, 1'b0, s_a, s_b);
    vt[3] = '{64'hFFFF_0000_A5A5_5A5A, HDR_CTRL, 1'b0, 64'h0};
    vt[3].exp = ref_scramble(vt[3].data, 1'b0, s_b, s_c);

    do_reset("por");

    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      bus.in_valid = 1'b1;
      bus.in_data  = vt[k].data;
      bus.in_hdr   = vt[k].hdr;
      bus.bypass   = vt[k].byp;
      @(negedge CLK);
      bus.in_valid = 1'b0;
      bus.bypass   = 1'b0;
      chk($sformatf("vec%0d_latency", k), {63'd0, bus.out_valid}, 64'd1);
      chk($sformatf("vec%0d_data", k), bus.out_data, vt[k].exp);
      chk($sformatf("vec%0d_hdr", k), {62'd0, bus.out_hdr}, {62'd0, vt[k].hdr});
    end
    drain();

    // Stall: output full, one beat into skid, then in_ready must drop.
    acc = 0;
    @(negedge CLK);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge CLK);
      bus.in_valid = 1'b1;
      bus.in_data  = {$urandom, $urandom};
      bus.in_hdr   = HDR_DATA;
      if (i >= 2) chk($sformatf("stall_in_ready_%0d", i), {63'd0, bus.in_ready}, 64'd0);
      if (bus.in_ready) acc++;
    end
    chk("stall_accepts", 64'(acc), 64'd2);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      bus.out_ready = 1'b1;
      bus.in_valid  = (acc < 4);
      bus.in_data   = {$urandom, $urandom};
      chk($sformatf("no_gap_%0d", i), {63'd0, bus.out_valid}, 64'd1);
      if (bus.in_valid && bus.in_ready) acc++;
    end
    chk("stall_total", 64'(acc), 64'd4);
    drain();

    // Seed load coincident with an accept: that beat uses the old state.
    d1 = {$urandom, $urandom};
    d2 = {$urandom, $urandom};
    tmp64 = {$urandom, $urandom};
    @(negedge CLK);
    bus.in_valid = 1'b1;
    bus.in_data  = d1;
    bus.in_hdr   = HDR_DATA;
    seed_load    = 1'b1;
    seed_value   = tmp64[57:0];
    @(negedge CLK);
    seed_load    = 1'b0;
    bus.in_data  = d2;
    @(negedge CLK);
    bus.in_valid = 1'b0;
    exp2 = ref_scramble(d2, 1'b0, tmp64[57:0], s_c);
    chk("seed_wins_data", bus.out_data, exp2);
    drain();

    random_pass(1000);
    tmp64 = {$urandom, $urandom};
    @(negedge CLK);
    seed_load  = 1'b1;
    seed_value = tmp64[57:0];
    @(negedge CLK);
    seed_load  = 1'b0;
    random_pass(300);

    // Header error counting and saturation.
    chk("err_cnt_start", {48'd0, hdr_err_cnt}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      bus.in_valid = 1'b1;
      bus.in_data  = {$urandom, $urandom};
      bus.in_hdr   = 2'b00;
    end
    @(negedge CLK);
    bus.in_valid = 1'b0;
    chk("err_cnt_3", {48'd0, hdr_err_cnt}, 64'd3);
    acc = 0;
    for (int cyc = 0; cyc < 70000 && acc < 65532; cyc++) begin
      @(negedge CLK);
      bus.in_valid = 1'b1;
      bus.in_data  = {$urandom, $urandom};
      bus.in_hdr   = 2'b11;
      if (bus.in_ready) acc++;
    end
    @(negedge CLK);
    bus.in_valid = 1'b0;
    chk("err_cnt_full", {48'd0, hdr_err_cnt}, 64'hFFFF);
    @(negedge CLK);
    bus.in_valid = 1'b1;
    bus.in_hdr   = 2'b11;
    @(negedge CLK);
    bus.in_valid = 1'b0;
    chk("err_cnt_sat", {48'd0, hdr_err_cnt}, 64'hFFFF);
    chk("err_cnt_model", {48'd0, hdr_err_cnt}, 64'(model_cnt));
    drain();

    // Reset with the output stage and skid both holding beats.
    @(negedge CLK);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_hdr    = HDR_DATA;
    bus.in_data   = {$urandom, $urandom};
    @(negedge CLK);
    bus.in_data   = {$urandom, $urandom};
    @(negedge CLK);
    bus.in_valid  = 1'b0;
    chk("mid_out_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("mid_skid_full", {63'd0, bus.in_ready}, 64'd0);
    do_reset("mid");
    @(negedge CLK);
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h0;
    bus.in_hdr   = HDR_DATA;
    @(negedge CLK);
    bus.in_valid = 1'b0;
    chk("post_reset_data", bus.out_data, 64'h03FF_FF80_0000_0000);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
